// File: rtl/sel_scan_sequencer.sv
// Select-code sweep generator for a 2^SEL_W-output decoder: steps through every
// code up or down, holding each for dwell+1 cycles, in single-shot or continuous mode.
module sel_scan_sequencer #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic               dir_down,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               down_q, down_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  logic [SEL_W-1:0]   first_code;
  logic [SEL_W-1:0]   last_code;
  logic               dwell_end;

  // Endpoints of the sweep follow the direction captured at start.
  assign first_code = down_q ? '1 : '0;
  assign last_code  = down_q ? '0 : '1;
  assign dwell_end  = (cnt_q == dwell_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      down_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      down_q  <= down_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    down_d  = down_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        cnt_d = '0;
        // stop has priority over start so a simultaneous pair is a no-op.
        if (start && !stop) begin
          dwell_d = dwell;
          cont_d  = mode_cont;
          down_d  = dir_down;
          sel_d   = dir_down ? '1 : '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (sel_q == last_code) begin
            if (cont_q) begin
              sel_d  = first_code;
              wrap_d = 1'b1;
            end else begin
              state_d = IDLE;
              sel_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            sel_d = down_q ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    sel       = sel_q;
    sel_valid = (state_q == RUN);
    busy      = (state_q == RUN);
    wrap      = wrap_q;
    done      = done_q;
  end

endmodule

// File: doc/sel_scan_sequencer.md
Name: sel_scan_sequencer

Overview:
Upstream driver for the 3-to-8 decoder. It generates the 3-bit select code that feeds the decoder input. On a start command it steps through all eight codes, either up or down, and holds each code for a programmable dwell time. It supports a single-shot sweep or a continuous sweep, and reports valid, busy, wrap and done status to the surrounding control logic.

Parameters:
- SEL_W, 3, select code width; the sweep covers codes 0 to 2^SEL_W-1.
- DWELL_W, 8, width of the dwell-time input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  begin a sweep; sampled only in IDLE.
- stop  input  1  abort an active sweep.
- mode_cont  input  1  1 = continuous sweep, 0 = single-shot; captured at start.
- dir_down  input  1  1 = count down (7 to 0), 0 = count up (0 to 7); captured at start.
- dwell  input  DWELL_W  extra hold cycles per code; captured at start.
- sel  output  SEL_W  select code to the decoder input.
- sel_valid  output  1  sel is an active scan code.
- busy  output  1  sweep in progress (state RUN).
- wrap  output  1  one-cycle pulse when a continuous sweep restarts at the first code.
- done  output  1  one-cycle pulse when a single-shot sweep completes.

Behaviour:
- The clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: sel=0, sel_valid=0, busy=0, wrap=0, done=0, state=IDLE, dwell counter=0, captured config=0.
- States: IDLE and RUN. done is a registered pulse, not a separate state.
- IDLE:
  - sel=0, sel_valid=0, busy=0.
  - When start=1 and stop=0 at a clock edge:
    - capture mode_cont, dir_down and dwell;
    - at that same edge set sel to the first code (0 if up, 7 if down), set sel_valid=1 and busy=1, clear the counter, and enter RUN.
  - When start=1 and stop=1 in the same cycle, stop wins and the block stays in IDLE.
- RUN, dwell:
  - Each code is held for exactly dwell_q+1 cycles.
  - The counter increments every cycle.
  - When the counter equals dwell_q, the next edge advances sel and clears the counter.
- RUN, advance:
  - up: sel+1; down: sel-1.
  - All arithmetic is SEL_W bits, unsigned.
- RUN, end of last code (7 if up, 0 if down) after its dwell:
  - continuous: sel takes the first code, wrap=1 for that one cycle, and the block stays in RUN.
  - single-shot: go to IDLE with sel=0, sel_valid=0, busy=0, and done=1 for one cycle.
- A single-shot sweep therefore keeps busy high for exactly 8*(dwell_q+1) cycles.
- stop=1 in RUN: at the next edge go to IDLE with sel=0 and sel_valid=0. done and wrap are not asserted. This takes priority over advance and wrap in the same cycle.
- start while in RUN is ignored. Changes on mode_cont, dir_down or dwell during RUN are ignored.
- done and wrap are never high simultaneously. Each is high for at most one cycle per event.
- done can coincide with a new start being sampled only on the following cycle. Back-to-back sweeps therefore have a minimum 1-cycle IDLE gap.
- Reset asserted mid-sweep: all outputs go to their reset values immediately, with no done pulse.
- The maximum dwell (2^DWELL_W-1) must work without counter overflow. The counter is DWELL_W bits wide.

Test Plan:
- Reset, then start, single-shot, up, dwell=0:
  - sel = 0,1,2,...,7 on 8 consecutive cycles with sel_valid=1 and busy=1;
  - the next cycle has done=1, sel=0, sel_valid=0;
  - the cycle after has done=0.
- Single-shot, down, dwell=2:
  - each code 7 to 0 is held 3 cycles;
  - busy is high for 24 cycles;
  - a single done pulse follows and wrap stays 0.
- Continuous, up, dwell=1:
  - after code 7 has been held 2 cycles, sel=0 with wrap=1 for one cycle;
  - a second full sweep follows and done stays 0;
  - stop asserted during code 3 gives sel=0, sel_valid=0, busy=0 at the next edge, with no done.
- Robustness:
  - start during RUN has no effect;
  - changing dwell or dir_down mid-sweep does not alter timing or direction;
  - start and stop asserted together in IDLE leave busy=0.
- Reset and back-to-back sweeps:
  - rst_n pulled low mid-sweep at code 5 clears all outputs to 0 asynchronously, before the next clock edge;
  - after release, start begins cleanly at code 0;
  - start asserted the cycle after done launches a new sweep.
